// File: rtl/riscv_pipeline_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_pipeline_top : five-stage RV32I-subset core with on-chip IMEM/DMEM   |
// | riscv_regfile      : 2R/1W write-first register file                       |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

module riscv_regfile (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);
  logic [31:0] regs [0:31];
  logic        w_wr_en;

  assign w_wr_en = i_we && (i_waddr != 5'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (w_wr_en) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  // A same-cycle WB write is visible to the ID read
  always_comb begin
    o_rdata1 = regs[i_raddr1];
    o_rdata2 = regs[i_raddr2];
    if (i_raddr1 == 5'd0)                         o_rdata1 = 32'd0;
    else if (w_wr_en && (i_waddr == i_raddr1))    o_rdata1 = i_wdata;
    if (i_raddr2 == 5'd0)                         o_rdata2 = 32'd0;
    else if (w_wr_en && (i_waddr == i_raddr2))    o_rdata2 = i_wdata;
  end
endmodule

module riscv_pipeline_top (
  input logic sys_clk,
  input logic sys_rst_n
);
  localparam logic [31:0] c_NOP       = 32'h0000_0013;
  localparam logic [6:0]  c_OP_R      = 7'b0110011;
  localparam logic [6:0]  c_OP_I      = 7'b0010011;
  localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
  localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
  localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
  localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
  localparam logic [6:0]  c_OP_AUIPC  = 7'b0010111;
  localparam logic [2:0]  c_ALU_ADD   = 3'd0;
  localparam logic [2:0]  c_ALU_SUB   = 3'd1;
  localparam logic [2:0]  c_ALU_AND   = 3'd2;
  localparam logic [2:0]  c_ALU_OR    = 3'd3;
  localparam logic [2:0]  c_ALU_XOR   = 3'd4;
  localparam logic [2:0]  c_ALU_SLT   = 3'd5;
  localparam logic [2:0]  c_ALU_SLTU  = 3'd6;
  localparam logic [2:0]  c_ALU_PASSB = 3'd7;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       jalr;
    logic       a_pc;
    logic       b_imm;
    logic [2:0] alu_op;
  } ctrl_t;

  logic [31:0] imem [0:1023];
  logic [31:0] dmem [0:1023];

  logic        r_started;
  logic [31:0] r_pc;
  logic [31:0] r_ifid_pc, r_ifid_instr;
  ctrl_t       r_idex_ctrl;
  logic [31:0] r_idex_pc, r_idex_rs1_val, r_idex_rs2_val, r_idex_imm;
  logic [4:0]  r_idex_rs1, r_idex_rs2, r_idex_rd;
  logic        r_exmem_reg_write, r_exmem_mem_read, r_exmem_mem_write;
  logic [4:0]  r_exmem_rd;
  logic [31:0] r_exmem_result, r_exmem_store;
  logic        r_memwb_reg_write;
  logic [4:0]  r_memwb_rd;
  logic [31:0] r_memwb_wdata;

  // ---------------- ID ----------------
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [31:0] w_rs1_val, w_rs2_val, w_imm, w_instr;
  ctrl_t       w_ctrl;
  logic        w_use_rs1, w_use_rs2, w_load_use;

  assign w_instr  = r_ifid_instr;
  assign w_opcode = w_instr[6:0];
  assign w_funct3 = w_instr[14:12];
  assign w_rd     = w_instr[11:7];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];

  riscv_regfile u_regfile (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst_n),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rs1_val),
    .o_rdata2 (w_rs2_val),
    .i_we     (r_memwb_reg_write),
    .i_waddr  (r_memwb_rd),
    .i_wdata  (r_memwb_wdata)
  );

  always_comb begin
    w_ctrl    = '0;
    w_imm     = 32'd0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      c_OP_R: begin
        w_ctrl.reg_write = 1'b1;
        case (w_funct3)
          3'b000:  w_ctrl.alu_op = w_instr[30] ? c_ALU_SUB : c_ALU_ADD;
          3'b111:  w_ctrl.alu_op = c_ALU_AND;
          3'b110:  w_ctrl.alu_op = c_ALU_OR;
          3'b100:  w_ctrl.alu_op = c_ALU_XOR;
          3'b010:  w_ctrl.alu_op = c_ALU_SLT;
          3'b011:  w_ctrl.alu_op = c_ALU_SLTU;
          default: w_ctrl.reg_write = 1'b0;
        endcase
        w_use_rs1 = w_ctrl.reg_write;
        w_use_rs2 = w_ctrl.reg_write;
      end
      c_OP_I: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.b_imm     = 1'b1;
        w_imm            = {{20{w_instr[31]}}, w_instr[31:20]};
        case (w_funct3)
          3'b000:  w_ctrl.alu_op = c_ALU_ADD;
          3'b111:  w_ctrl.alu_op = c_ALU_AND;
          3'b110:  w_ctrl.alu_op = c_ALU_OR;
          3'b100:  w_ctrl.alu_op = c_ALU_XOR;
          3'b010:  w_ctrl.alu_op = c_ALU_SLT;
          default: w_ctrl.reg_write = 1'b0;
        endcase
        w_use_rs1 = w_ctrl.reg_write;
      end
      c_OP_LOAD: if (w_funct3 == 3'b010) begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.b_imm     = 1'b1;
        w_imm            = {{20{w_instr[31]}}, w_instr[31:20]};
        w_use_rs1        = 1'b1;
      end
      c_OP_STORE: if (w_funct3 == 3'b010) begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.b_imm     = 1'b1;
        w_imm            = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
        w_use_rs1        = 1'b1;
        w_use_rs2        = 1'b1;
      end
      c_OP_BRANCH: if (w_funct3[2:1] == 2'b00) begin
        w_ctrl.branch    = 1'b1;
        w_ctrl.branch_ne = w_funct3[0];
        w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
        w_use_rs1        = 1'b1;
        w_use_rs2        = 1'b1;
      end
      c_OP_JAL: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.jump      = 1'b1;
        w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
      end
      c_OP_JALR: if (w_funct3 == 3'b000) begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.jump      = 1'b1;
        w_ctrl.jalr      = 1'b1;
        w_imm            = {{20{w_instr[31]}}, w_instr[31:20]};
        w_use_rs1        = 1'b1;
      end
      c_OP_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.b_imm     = 1'b1;
        w_ctrl.alu_op    = c_ALU_PASSB;
        w_imm            = {w_instr[31:12], 12'd0};
      end
      c_OP_AUIPC: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.a_pc      = 1'b1;
        w_ctrl.b_imm     = 1'b1;
        w_imm            = {w_instr[31:12], 12'd0};
      end
      default: ;
    endcase
  end

  assign w_load_use = r_idex_ctrl.mem_read && (r_idex_rd != 5'd0) &&
                      ((w_use_rs1 && (w_rs1 == r_idex_rd)) || (w_use_rs2 && (w_rs2 == r_idex_rd)));

  // ---------------- EX ----------------
  logic [31:0] w_fwd_a, w_fwd_b, w_alu_a, w_alu_b, w_alu_out, w_ex_result, w_target;
  logic        w_br_taken, w_redirect;

  always_comb begin
    w_fwd_a = r_idex_rs1_val;
    w_fwd_b = r_idex_rs2_val;
    if (r_exmem_reg_write && !r_exmem_mem_read && (r_exmem_rd != 5'd0) && (r_exmem_rd == r_idex_rs1))
      w_fwd_a = r_exmem_result;
    else if (r_memwb_reg_write && (r_memwb_rd != 5'd0) && (r_memwb_rd == r_idex_rs1))
      w_fwd_a = r_memwb_wdata;
    if (r_exmem_reg_write && !r_exmem_mem_read && (r_exmem_rd != 5'd0) && (r_exmem_rd == r_idex_rs2))
      w_fwd_b = r_exmem_result;
    else if (r_memwb_reg_write && (r_memwb_rd != 5'd0) && (r_memwb_rd == r_idex_rs2))
      w_fwd_b = r_memwb_wdata;
  end

  assign w_alu_a = r_idex_ctrl.a_pc  ? r_idex_pc  : w_fwd_a;
  assign w_alu_b = r_idex_ctrl.b_imm ? r_idex_imm : w_fwd_b;

  always_comb begin
    w_alu_out = w_alu_a + w_alu_b;
    case (r_idex_ctrl.alu_op)
      c_ALU_SUB:   w_alu_out = w_alu_a - w_alu_b;
      c_ALU_AND:   w_alu_out = w_alu_a & w_alu_b;
      c_ALU_OR:    w_alu_out = w_alu_a | w_alu_b;
      c_ALU_XOR:   w_alu_out = w_alu_a ^ w_alu_b;
      c_ALU_SLT:   w_alu_out = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
      c_ALU_SLTU:  w_alu_out = {31'd0, w_alu_a < w_alu_b};
      c_ALU_PASSB: w_alu_out = w_alu_b;
      default:     ;
    endcase
  end

  assign w_ex_result = r_idex_ctrl.jump ? (r_idex_pc + 32'd4) : w_alu_out;
  assign w_br_taken  = r_idex_ctrl.branch && ((w_fwd_a == w_fwd_b) != r_idex_ctrl.branch_ne);
  assign w_redirect  = w_br_taken || r_idex_ctrl.jump;
  assign w_target    = r_idex_ctrl.jalr ? ((w_fwd_a + r_idex_imm) & ~32'd1) : (r_idex_pc + r_idex_imm);

  // ---------------- MEM ----------------
  logic [31:0] w_wb_data;
  assign w_wb_data = r_exmem_mem_read ? dmem[r_exmem_result[11:2]] : r_exmem_result;

  always_ff @(posedge sys_clk) begin
    if (r_exmem_mem_write) dmem[r_exmem_result[11:2]] <= r_exmem_store;
  end

  // The first cycle after reset only primes the synchronous IMEM read
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_started         <= 1'b0;
      r_pc              <= 32'd0;
      r_ifid_pc         <= 32'd0;
      r_ifid_instr      <= c_NOP;
      r_idex_ctrl       <= '0;
      r_idex_pc         <= 32'd0;
      r_idex_rs1_val    <= 32'd0;
      r_idex_rs2_val    <= 32'd0;
      r_idex_imm        <= 32'd0;
      r_idex_rs1        <= 5'd0;
      r_idex_rs2        <= 5'd0;
      r_idex_rd         <= 5'd0;
      r_exmem_reg_write <= 1'b0;
      r_exmem_mem_read  <= 1'b0;
      r_exmem_mem_write <= 1'b0;
      r_exmem_rd        <= 5'd0;
      r_exmem_result    <= 32'd0;
      r_exmem_store     <= 32'd0;
      r_memwb_reg_write <= 1'b0;
      r_memwb_rd        <= 5'd0;
      r_memwb_wdata     <= 32'd0;
    end else begin
      r_started <= 1'b1;
      if (w_redirect) begin
        r_pc         <= w_target;
        r_ifid_pc    <= 32'd0;
        r_ifid_instr <= c_NOP;
      end else if (r_started && !w_load_use) begin
        r_pc         <= r_pc + 32'd4;
        r_ifid_pc    <= r_pc;
        r_ifid_instr <= imem[r_pc[11:2]];
      end

      if (w_redirect || w_load_use) begin
        r_idex_ctrl <= '0;
        r_idex_rs1  <= 5'd0;
        r_idex_rs2  <= 5'd0;
        r_idex_rd   <= 5'd0;
      end else begin
        r_idex_ctrl    <= w_ctrl;
        r_idex_pc      <= r_ifid_pc;
        r_idex_rs1_val <= w_rs1_val;
        r_idex_rs2_val <= w_rs2_val;
        r_idex_imm     <= w_imm;
        r_idex_rs1     <= w_rs1;
        r_idex_rs2     <= w_rs2;
        r_idex_rd      <= w_rd;
      end

      r_exmem_reg_write <= r_idex_ctrl.reg_write;
      r_exmem_mem_read  <= r_idex_ctrl.mem_read;
      r_exmem_mem_write <= r_idex_ctrl.mem_write;
      r_exmem_rd        <= r_idex_rd;
      r_exmem_result    <= w_ex_result;
      r_exmem_store     <= w_fwd_b;

      r_memwb_reg_write <= r_exmem_reg_write;
      r_memwb_rd        <= r_exmem_rd;
      r_memwb_wdata     <= w_wb_data;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_riscv_pipeline_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_riscv_pipeline_top : scoreboard bench for the pipelined RV32I core       |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

module tb_riscv_pipeline_top;
  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  always #10 sys_clk = ~sys_clk;

  riscv_pipeline_top dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  wb_t sb_q [$];
  wb_t exp_list [$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;
  int  t_x5  = 0;
  int  t_x6  = 0;
  int  load_idx = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Loads one instruction and records the register write it must produce (rd 0 = none)
  task automatic emit(input logic [31:0] ins, input logic [4:0] rd, input logic [31:0] val);
    wb_t e;
    dut.imem[load_idx] = ins;
    load_idx++;
    if (rd != 5'd0) begin
      e.rd  = rd;
      e.val = val;
      exp_list.push_back(e);
      sb_q.push_back(e);
    end
  endtask

  task automatic repush();
    sb_q.delete();
    foreach (exp_list[i]) sb_q.push_back(exp_list[i]);
  endtask

  always @(negedge sys_clk) begin
    wb_t e;
    if (sys_rst_n) cyc++;
    if (sys_rst_n && dut.u_regfile.i_we && (dut.u_regfile.i_waddr != 5'd0)) begin
      if (dut.u_regfile.i_waddr == 5'd5) t_x5 = cyc;
      if (dut.u_regfile.i_waddr == 5'd6) t_x6 = cyc;
      if (sb_q.size() == 0) begin
        check_value("wb_extra", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        check_value("wb", {27'd0, dut.u_regfile.i_waddr, dut.u_regfile.i_wdata}, {27'd0, e.rd, e.val});
      end
    end
  end

  task automatic check_reset_state(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.u_regfile.regs[i] != 32'd0) nz++;
    check_value({tag, "_regs_nonzero"}, 64'(nz), 64'd0);
    check_value({tag, "_pc"}, {32'd0, dut.r_pc}, 64'd0);
  endtask

  task automatic run_until_drained(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge sys_clk);
      n++;
    end
    repeat (8) @(posedge sys_clk);
    #1;
    check_value({tag, "_drain"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_final(input string tag);
    logic in_loop;
    check_value({tag, "_x3"},  {32'd0, dut.u_regfile.regs[3]},  64'd12);
    check_value({tag, "_x4"},  {32'd0, dut.u_regfile.regs[4]},  64'hFFFF_FFFE);
    check_value({tag, "_x1"},  {32'd0, dut.u_regfile.regs[1]},  64'd16);
    check_value({tag, "_x6"},  {32'd0, dut.u_regfile.regs[6]},  64'd24);
    check_value({tag, "_dmem2"}, {32'd0, dut.dmem[2]},          64'd12);
    check_value({tag, "_x7_shadow"},  {32'd0, dut.u_regfile.regs[7]},  64'd0);
    check_value({tag, "_x10_bne_ft"}, {32'd0, dut.u_regfile.regs[10]}, 64'd3);
    check_value({tag, "_x8_link"},    {32'd0, dut.u_regfile.regs[8]},  64'd72);
    check_value({tag, "_x11_shadow"}, {32'd0, dut.u_regfile.regs[11]}, 64'd0);
    check_value({tag, "_x0"},  {32'd0, dut.u_regfile.regs[0]},  64'd0);
    check_value({tag, "_x9"},  {32'd0, dut.u_regfile.regs[9]},  64'd0);
    check_value({tag, "_x13_wrap"},   {32'd0, dut.u_regfile.regs[13]}, 64'h8000_0000);
    check_value({tag, "_x17_jalr"},   {32'd0, dut.u_regfile.regs[17]}, 64'd112);
    check_value({tag, "_x18_shadow"}, {32'd0, dut.u_regfile.regs[18]}, 64'd0);
    check_value({tag, "_x31_illegal"},{32'd0, dut.u_regfile.regs[31]}, 64'd0);
    check_value({tag, "_load_use_gap"}, 64'(t_x6 - t_x5), 64'd2);
    in_loop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk);
      #1;
      if (dut.r_pc < 32'd152 || dut.r_pc > 32'd160) in_loop = 1'b0;
    end
    check_value({tag, "_pc_in_loop"}, {63'd0, in_loop}, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h0000_0013;

    emit(enc_i(7'b0010011, 3'b000, 5'd1, 5'd0, 12'd5), 5'd1, 32'd5);              // 0
    emit(enc_i(7'b0010011, 3'b000, 5'd2, 5'd0, 12'd7), 5'd2, 32'd7);              // 4
    emit(enc_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2), 5'd3, 32'd12);                   // 8
    emit(enc_r(7'h20, 3'b000, 5'd4, 5'd1, 5'd2), 5'd4, 32'hFFFF_FFFE);            // 12
    emit(enc_i(7'b0010011, 3'b000, 5'd1, 5'd0, 12'd1), 5'd1, 32'd1);              // 16
    emit(enc_r(7'h00, 3'b000, 5'd1, 5'd1, 5'd1), 5'd1, 32'd2);                    // 20
    emit(enc_r(7'h00, 3'b000, 5'd1, 5'd1, 5'd1), 5'd1, 32'd4);                    // 24
    emit(enc_r(7'h00, 3'b000, 5'd1, 5'd1, 5'd1), 5'd1, 32'd8);                    // 28
    emit(enc_r(7'h00, 3'b000, 5'd1, 5'd1, 5'd1), 5'd1, 32'd16);                   // 32
    emit(enc_s(5'd3, 5'd0, 12'd8), 5'd0, 32'd0);                                  // 36 SW
    emit(enc_i(7'b0000011, 3'b010, 5'd5, 5'd0, 12'd8), 5'd5, 32'd12);             // 40 LW
    emit(enc_r(7'h00, 3'b000, 5'd6, 5'd5, 5'd5), 5'd6, 32'd24);                   // 44
    emit(enc_b(3'b000, 5'd1, 5'd1, 13'd12), 5'd0, 32'd0);                         // 48 BEQ
    emit(enc_i(7'b0010011, 3'b000, 5'd7, 5'd0, 12'd1), 5'd0, 32'd0);              // 52 shadow
    emit(enc_i(7'b0010011, 3'b000, 5'd7, 5'd0, 12'd2), 5'd0, 32'd0);              // 56 shadow
    emit(enc_b(3'b001, 5'd1, 5'd1, 13'd8), 5'd0, 32'd0);                          // 60 BNE
    emit(enc_i(7'b0010011, 3'b000, 5'd10, 5'd0, 12'd3), 5'd10, 32'd3);            // 64
    emit(enc_j(5'd8, 21'd8), 5'd8, 32'd72);                                       // 68 JAL
    emit(enc_i(7'b0010011, 3'b000, 5'd11, 5'd0, 12'd1), 5'd0, 32'd0);             // 72 shadow
    emit(enc_i(7'b0010011, 3'b000, 5'd0, 5'd0, 12'd99), 5'd0, 32'd0);             // 76
    emit(enc_r(7'h00, 3'b000, 5'd9, 5'd0, 5'd0), 5'd9, 32'd0);                    // 80
    emit({20'h80000, 5'd12, 7'b0110111}, 5'd12, 32'h8000_0000);                   // 84 LUI
    emit(enc_i(7'b0010011, 3'b000, 5'd12, 5'd12, 12'hFFF), 5'd12, 32'h7FFF_FFFF); // 88
    emit(enc_i(7'b0010011, 3'b000, 5'd13, 5'd12, 12'd1), 5'd13, 32'h8000_0000);   // 92
    emit(enc_r(7'h00, 3'b010, 5'd14, 5'd13, 5'd12), 5'd14, 32'd1);                // 96 SLT
    emit(enc_r(7'h00, 3'b011, 5'd15, 5'd13, 5'd12), 5'd15, 32'd0);                // 100 SLTU
    emit({20'h00001, 5'd16, 7'b0010111}, 5'd16, 32'h0000_1068);                   // 104 AUIPC
    emit(enc_i(7'b1100111, 3'b000, 5'd17, 5'd10, 12'd118), 5'd17, 32'd112);       // 108 JALR
    emit(enc_i(7'b0010011, 3'b000, 5'd18, 5'd0, 12'd1), 5'd0, 32'd0);             // 112 shadow
    emit(enc_i(7'b0010011, 3'b000, 5'd18, 5'd0, 12'd2), 5'd0, 32'd0);             // 116 shadow
    emit(enc_i(7'b0010011, 3'b100, 5'd19, 5'd4, 12'hFFF), 5'd19, 32'd1);          // 120 XORI
    emit(enc_i(7'b0010011, 3'b111, 5'd20, 5'd3, 12'd4), 5'd20, 32'd4);            // 124 ANDI
    emit(enc_i(7'b0010011, 3'b110, 5'd21, 5'd3, 12'd3), 5'd21, 32'd15);           // 128 ORI
    emit(enc_i(7'b0010011, 3'b010, 5'd22, 5'd4, 12'd0), 5'd22, 32'd1);            // 132 SLTI
    emit(enc_r(7'h00, 3'b111, 5'd23, 5'd3, 5'd6), 5'd23, 32'd8);                  // 136 AND
    emit(enc_r(7'h00, 3'b110, 5'd24, 5'd3, 5'd6), 5'd24, 32'd28);                 // 140 OR
    emit(enc_r(7'h00, 3'b100, 5'd25, 5'd3, 5'd6), 5'd25, 32'd20);                 // 144 XOR
    emit(32'hFFFF_FFFF, 5'd0, 32'd0);                                             // 148 unsupported
    emit(enc_j(5'd0, 21'd0), 5'd0, 32'd0);                                        // 152 self-loop

    repeat (2) @(posedge sys_clk);
    #1;
    check_reset_state("por");
    check_value("por_ifid_bubble", {32'd0, dut.r_ifid_instr}, 64'h13);
    sys_rst_n = 1'b1;
    run_until_drained("run1");
    check_final("run1");

    // Restart, then abort mid-program with a 2-cycle reset pulse
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    repush();
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (15) @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check_reset_state("midrst");
    check_value("midrst_dmem_kept", {32'd0, dut.dmem[2]}, 64'd12);
    repush();
    sys_rst_n = 1'b1;
    run_until_drained("run2");
    check_final("run2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
